// File: rtl/r_ctrl_fsm.sv
// rtl/r_ctrl_fsm.sv - multi-cycle fetch/decode/execute/write-back control unit for the R-type datapath
module r_ctrl_fsm #(
   parameter int unsigned CNT_W    = 16,
   parameter bit          OF_BLOCK = 1'b1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [31:0]      Inst_code,
   input  logic             ZF,
   input  logic             OF,
   output logic             PC_Write,
   output logic             IR_Write,
   output logic             Reg_Write,
   output logic [4:0]       rs,
   output logic [4:0]       rt,
   output logic [4:0]       rd,
   output logic [4:0]       Shamt,
   output logic [2:0]       ALU_OP,
   output logic [2:0]       state,
   output logic             ZF_q,
   output logic             OF_q,
   output logic             Illegal,
   output logic [CNT_W-1:0] Inst_cnt
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_IF   = 3'd1,
      S_ID   = 3'd2,
      S_EX   = 3'd3,
      S_WB   = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [4:0]       rs_q, rs_d;
   logic [4:0]       rt_q, rt_d;
   logic [4:0]       rd_q, rd_d;
   logic [4:0]       shamt_q, shamt_d;
   logic [2:0]       alu_op_q, alu_op_d;
   logic             zf_q, zf_d;
   logic             of_q, of_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] inst_cnt_q, inst_cnt_d;

   logic             dec_legal;
   logic [2:0]       dec_alu_op;

   always_comb begin
      dec_legal  = 1'b0;
      dec_alu_op = 3'b000;
      if (Inst_code[31:26] == 6'h00) begin
         dec_legal = 1'b1;
         case (Inst_code[5:0])
            6'h24:   dec_alu_op = 3'b000;
            6'h25:   dec_alu_op = 3'b001;
            6'h26:   dec_alu_op = 3'b010;
            6'h27:   dec_alu_op = 3'b011;
            6'h20:   dec_alu_op = 3'b100;
            6'h22:   dec_alu_op = 3'b101;
            6'h2A:   dec_alu_op = 3'b110;
            6'h00:   dec_alu_op = 3'b111;
            default: dec_legal  = 1'b0;
         endcase
      end
   end

   // Every register holds by default; each state updates only the fields it owns.
   always_comb begin
      state_d    = state_q;
      rs_d       = rs_q;
      rt_d       = rt_q;
      rd_d       = rd_q;
      shamt_d    = shamt_q;
      alu_op_d   = alu_op_q;
      zf_d       = zf_q;
      of_d       = of_q;
      illegal_d  = illegal_q;
      inst_cnt_d = inst_cnt_q;
      case (state_q)
         S_IDLE: state_d = S_IF;
         S_IF:   state_d = S_ID;
         S_ID: begin
            illegal_d = ~dec_legal;
            if (dec_legal) begin
               rs_d     = Inst_code[25:21];
               rt_d     = Inst_code[20:16];
               rd_d     = Inst_code[15:11];
               shamt_d  = Inst_code[10:6];
               alu_op_d = dec_alu_op;
               state_d  = S_EX;
            end else begin
               state_d  = S_IF;
            end
         end
         S_EX: begin
            zf_d    = ZF;
            of_d    = OF;
            state_d = S_WB;
         end
         S_WB: begin
            inst_cnt_d = inst_cnt_q + CNT_W'(1);
            state_d    = S_IF;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= S_IDLE;
         rs_q       <= '0;
         rt_q       <= '0;
         rd_q       <= '0;
         shamt_q    <= '0;
         alu_op_q   <= '0;
         zf_q       <= 1'b0;
         of_q       <= 1'b0;
         illegal_q  <= 1'b0;
         inst_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         rd_q       <= rd_d;
         shamt_q    <= shamt_d;
         alu_op_q   <= alu_op_d;
         zf_q       <= zf_d;
         of_q       <= of_d;
         illegal_q  <= illegal_d;
         inst_cnt_q <= inst_cnt_d;
      end
   end

   // Strobes are forced low while RST is high so a reset landing mid-instruction never writes.
   assign PC_Write  = ~RST && (state_q == S_IF);
   assign IR_Write  = ~RST && (state_q == S_IF);
   assign Reg_Write = ~RST && (state_q == S_WB) && (rd_q != 5'd0) && !(OF_BLOCK && of_q);

   assign rs       = rs_q;
   assign rt       = rt_q;
   assign rd       = rd_q;
   assign Shamt    = shamt_q;
   assign ALU_OP   = alu_op_q;
   assign state    = state_q;
   assign ZF_q     = zf_q;
   assign OF_q     = of_q;
   assign Illegal  = illegal_q;
   assign Inst_cnt = inst_cnt_q;

endmodule

// File: doc/r_ctrl_fsm.md
Name: r_ctrl_fsm

Overview:
Multi-cycle control unit that sits directly upstream of the R-type datapath (PC register, instruction memory, register file, ALU). It sequences each instruction through fetch, decode, execute and write-back. It decodes the 32-bit instruction word into register addresses and a 3-bit ALU opcode, and gates register write-back on the ALU flags. It also counts retired instructions for bench and board visibility.

Parameters:
CNT_W, 16, width of retired-instruction counter (wraps modulo 2^CNT_W)
OF_BLOCK, 1, when 1, suppress register write-back if ALU OF was set in EX

Ports:
CLK  in  1  system clock; all state updates on rising edge
RST  in  1  synchronous active-high reset
Inst_code  in  32  instruction word from the IR; valid from the ID state onward
ZF  in  1  ALU zero flag, valid in EX
OF  in  1  ALU overflow flag, valid in EX
PC_Write  out  1  PC <= PC+4 strobe
IR_Write  out  1  IR load strobe
Reg_Write  out  1  register-file write strobe
rs  out  5  source register A address
rt  out  5  source register B address
rd  out  5  destination register address
Shamt  out  5  shift amount for SLL
ALU_OP  out  3  ALU function select
state  out  3  current FSM state, for debug
ZF_q  out  1  ZF latched at end of EX
OF_q  out  1  OF latched at end of EX
Illegal  out  1  last decoded instruction was illegal
Inst_cnt  out  CNT_W  retired-instruction count

Behaviour:
- Reset: RST=1 at a rising edge forces state=IDLE(0). It clears rs, rt, rd, Shamt, ALU_OP, ZF_q, OF_q, Illegal and Inst_cnt to 0. Reset takes priority over every transition, including mid-instruction.
- States: IDLE=0, IF=1, ID=2, EX=3, WB=4. Codes 5-7 go to IDLE on the next edge.
- Transitions: IDLE->IF; IF->ID; ID->EX if legal, ID->IF if illegal; EX->WB; WB->IF.
- Strobes are Moore-decoded from state, so all three are 0 in IDLE and during reset.
  - PC_Write = IR_Write = 1 only in IF.
  - Reg_Write = 1 only in WB, when rd!=0 and !(OF_BLOCK && OF_q).
- Latency: 4 cycles per legal instruction; 2 cycles (IF, ID) per illegal instruction. The first IF is the cycle after the first edge with RST=0.
- Decode (registered at the ID->next edge):
  - rs=Inst_code[25:21], rt=[20:16], rd=[15:11], Shamt=[10:6].
  - Legal only when opcode [31:26]=0 and funct [5:0] is one of the following (funct->ALU_OP): 0x24 AND->000, 0x25 OR->001, 0x26 XOR->010, 0x27 NOR->011, 0x20 ADD->100, 0x22 SUB->101, 0x2A SLT->110, 0x00 SLL->111.
  - Illegal <= !legal at that same edge. Illegal holds until the next ID.
  - On an illegal instruction, rs/rt/rd/Shamt/ALU_OP keep their previous values.
- EX: at the EX->WB edge, ZF_q<=ZF and OF_q<=OF. Both hold until the next EX.
- Inst_cnt increments by 1 at every WB->IF edge, whether or not Reg_Write was suppressed. It wraps from 2^CNT_W-1 to 0. Illegal instructions do not count.
- Flag inputs are ignored outside EX.
- Inst_code is ignored outside ID, including changes mid-instruction.

Test Plan:
- RST=1 for 3 cycles, then 0 -> all outputs 0 during reset. state runs 0,1,2,3,4,1. PC_Write=IR_Write=1 exactly in the first IF cycle.
- Inst_code=0x00221820 (add $3,$1,$2), OF=0 -> after ID: rs=1, rt=2, rd=3, ALU_OP=100. Reg_Write=1 for exactly one cycle in WB. Inst_cnt 0->1.
- Inst_code=0x00222022 (sub $4,$1,$2), OF=1 in EX, OF_BLOCK=1 -> ALU_OP=101, OF_q=1, Reg_Write stays 0, Inst_cnt still increments. Repeat with OF_BLOCK=0 -> Reg_Write=1.
- Inst_code=0x8C220000 (opcode 0x23) -> Illegal=1 after ID, state 2->1 with no EX/WB, Inst_cnt unchanged. A following legal add clears Illegal at its ID.
- Inst_code=0x00220020 (rd=0) -> full 4-cycle sequence, Reg_Write never asserts, Inst_cnt increments.
- RST pulsed for 1 cycle while state=EX -> next state=IDLE, OF_q/ZF_q/Inst_cnt=0, no Reg_Write. With CNT_W=2, five retired adds -> Inst_cnt reads 1,2,3,0,1.
